// File: rtl/logo_motion_sequencer_if.sv
// ---------------------------------------------------------------------------
// logo_motion_sequencer_if
// Bundles the frame strobe, gamepad/speed inputs and the sprite-state outputs
// of the logo motion sequencer.
//   master : drives frame_start, speed, pad_*; observes sprite state
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface logo_motion_sequencer_if;
  logic       frame_start;
  logic [1:0] speed;
  logic       pad_up;
  logic       pad_down;
  logic       pad_left;
  logic       pad_right;
  logic       pad_start;
  logic [9:0] logo_left;
  logic [9:0] logo_top;
  logic [2:0] color_index;
  logic       manual_mode;
  logic       hit_pulse;
  logic       busy;

  modport master (
    output frame_start, speed, pad_up, pad_down, pad_left, pad_right, pad_start,
    input  logo_left, logo_top, color_index, manual_mode, hit_pulse, busy
  );

  modport slave (
    input  frame_start, speed, pad_up, pad_down, pad_left, pad_right, pad_start,
    output logo_left, logo_top, color_index, manual_mode, hit_pulse, busy
  );
endinterface

// File: rtl/logo_motion_sequencer.sv
// ---------------------------------------------------------------------------
// logo_motion_sequencer
// Once per video frame computes the next logo position, bounce direction and
// palette index, in auto-bounce or gamepad manual mode.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of logo_motion_sequencer_if (frame strobe, speed,
//           gamepad levels in; logo_left/top, color_index, manual_mode,
//           hit_pulse, busy out)
// All sprite outputs change together on the COMMIT->IDLE edge so the renderer
// never sees a half-updated X/Y pair.
// ---------------------------------------------------------------------------
module logo_motion_sequencer #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int LOGO_SIZE      = 128,
  parameter int START_X        = 200,
  parameter int START_Y        = 200,
  parameter int IDLE_FRAMES    = 600
) (
  input logic                    clk,
  input logic                    rst_n,
  logo_motion_sequencer_if.slave bus
);

  localparam logic [10:0] MAX_X    = 11'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [10:0] MAX_Y    = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
  localparam logic [15:0] IDLE_LIM = 16'(IDLE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_X = 2'd1,
    ST_CALC_Y = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic        snap_up_r, snap_down_r, snap_left_r, snap_right_r, snap_start_r;
  logic [1:0]  speed_r;
  logic [9:0]  x_pend_r, y_pend_r;
  logic        dir_x_pend_r, dir_y_pend_r, hit_x_r, hit_y_r;
  logic [9:0]  logo_left_r, logo_top_r;
  logic [2:0]  color_r;
  logic        manual_r, hit_pulse_r, busy_r;
  logic        dir_x_r, dir_y_r, start_prev_r;
  logic [15:0] idle_cnt_r;
  logic [11:0] axis_s;
  logic        toggle_s, any_dir_s, mode_next_s;
  logic [15:0] cnt_inc_s, cnt_next_s;

  // One axis step. dec/inc are the buttons toward 0 / toward lim.
  // Returns {hit, dir, pos}. 11-bit intermediates keep pos+s from wrapping.
  function automatic logic [11:0] axis_step(
    input logic [9:0]  pos,
    input logic        dir,
    input logic [1:0]  s,
    input logic [10:0] lim,
    input logic        manual,
    input logic        dec,
    input logic        inc
  );
    logic [10:0] p;
    logic [10:0] s11;
    logic [10:0] sum;
    logic        d;
    logic        h;
    p   = {1'b0, pos};
    s11 = {9'd0, s};
    sum = p + s11;
    d   = dir;
    h   = 1'b0;
    if (manual) begin
      // Opposing buttons cancel; direction flag is left untouched.
      if (dec && !inc) begin
        p = (p > s11) ? (p - s11) : 11'd0;
      end else if (inc && !dec) begin
        p = (sum >= lim) ? lim : sum;
      end else begin
        p = p;
      end
    end else begin
      // Steering takes effect before this frame's move.
      if (dec) begin
        d = 1'b0;
      end else if (inc) begin
        d = 1'b1;
      end else begin
        d = d;
      end
      // Comparisons use >= / <= so a frozen sprite parked on a wall it faces
      // still registers a bounce.
      if (d) begin
        if (sum >= lim) begin
          p = lim;
          d = 1'b0;
          h = 1'b1;
        end else begin
          p = sum;
        end
      end else begin
        if (p <= s11) begin
          p = 11'd0;
          d = 1'b1;
          h = 1'b1;
        end else begin
          p = p - s11;
        end
      end
    end
    return {h, d, p[9:0]};
  endfunction

  // Shared axis unit: X during CALC_X, Y otherwise.
  always_comb begin
    axis_s = 12'd0;
    if (state_r == ST_CALC_X) begin
      axis_s = axis_step(logo_left_r, dir_x_r, speed_r, MAX_X, manual_r,
                         snap_left_r, snap_right_r);
    end else begin
      axis_s = axis_step(logo_top_r, dir_y_r, speed_r, MAX_Y, manual_r,
                         snap_up_r, snap_down_r);
    end
  end

  // Mode/idle bookkeeping for the frame being committed; a start toggle wins
  // over the idle timeout, and the idle count only lives while in manual.
  always_comb begin
    toggle_s    = snap_start_r & ~start_prev_r;
    any_dir_s   = snap_up_r | snap_down_r | snap_left_r | snap_right_r;
    cnt_inc_s   = 16'd0;
    mode_next_s = 1'b0;
    cnt_next_s  = 16'd0;
    if (manual_r) begin
      if (any_dir_s) begin
        cnt_inc_s = 16'd0;
      end else begin
        cnt_inc_s = idle_cnt_r + 16'd1;
      end
      if (toggle_s) begin
        mode_next_s = 1'b0;
      end else if (cnt_inc_s >= IDLE_LIM) begin
        mode_next_s = 1'b0;
      end else begin
        mode_next_s = 1'b1;
      end
    end else begin
      mode_next_s = toggle_s;
    end
    if (mode_next_s) begin
      cnt_next_s = cnt_inc_s;
    end else begin
      cnt_next_s = 16'd0;
    end
  end

  // Next-state logic: fixed four-step walk, frame_start only heard in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_next_s = ST_CALC_X;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC_X: state_next_s = ST_CALC_Y;
      ST_CALC_Y: state_next_s = ST_COMMIT;
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot, per-axis results and atomic commit of the sprite state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_up_r    <= 1'b0;
      snap_down_r  <= 1'b0;
      snap_left_r  <= 1'b0;
      snap_right_r <= 1'b0;
      snap_start_r <= 1'b0;
      speed_r      <= 2'd0;
      x_pend_r     <= 10'(START_X);
      y_pend_r     <= 10'(START_Y);
      dir_x_pend_r <= 1'b1;
      dir_y_pend_r <= 1'b0;
      hit_x_r      <= 1'b0;
      hit_y_r      <= 1'b0;
      logo_left_r  <= 10'(START_X);
      logo_top_r   <= 10'(START_Y);
      color_r      <= 3'd0;
      manual_r     <= 1'b0;
      hit_pulse_r  <= 1'b0;
      busy_r       <= 1'b0;
      dir_x_r      <= 1'b1;
      dir_y_r      <= 1'b0;
      start_prev_r <= 1'b0;
      idle_cnt_r   <= 16'd0;
    end else begin
      hit_pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.frame_start) begin
            snap_up_r    <= bus.pad_up;
            snap_down_r  <= bus.pad_down;
            snap_left_r  <= bus.pad_left;
            snap_right_r <= bus.pad_right;
            snap_start_r <= bus.pad_start;
            speed_r      <= bus.speed;
            busy_r       <= 1'b1;
          end
        end
        ST_CALC_X: begin
          x_pend_r     <= axis_s[9:0];
          dir_x_pend_r <= axis_s[10];
          hit_x_r      <= axis_s[11];
        end
        ST_CALC_Y: begin
          y_pend_r     <= axis_s[9:0];
          dir_y_pend_r <= axis_s[10];
          hit_y_r      <= axis_s[11];
        end
        ST_COMMIT: begin
          logo_left_r  <= x_pend_r;
          logo_top_r   <= y_pend_r;
          dir_x_r      <= dir_x_pend_r;
          dir_y_r      <= dir_y_pend_r;
          // A corner hit still advances the palette by one.
          color_r      <= color_r + {2'b00, hit_x_r | hit_y_r};
          hit_pulse_r  <= hit_x_r | hit_y_r;
          manual_r     <= mode_next_s;
          idle_cnt_r   <= cnt_next_s;
          start_prev_r <= snap_start_r;
          busy_r       <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.logo_left   = logo_left_r;
  assign bus.logo_top    = logo_top_r;
  assign bus.color_index = color_r;
  assign bus.manual_mode = manual_r;
  assign bus.hit_pulse   = hit_pulse_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_logo_motion_sequencer.sv
// ---------------------------------------------------------------------------
// tb_logo_motion_sequencer
// Drives directed and random frames into logo_motion_sequencer and compares
// every committed frame against a behavioural model of the motion rules.
// ---------------------------------------------------------------------------
module tb_logo_motion_sequencer;

  localparam int MAXX = 512;
  localparam int MAXY = 352;
  localparam int IDLE = 4;

  logic clk;
  logic rst_n;
  logo_motion_sequencer_if bus();

  logo_motion_sequencer #(
    .DISPLAY_WIDTH (640),
    .DISPLAY_HEIGHT(480),
    .LOGO_SIZE     (128),
    .START_X       (200),
    .START_Y       (200),
    .IDLE_FRAMES   (IDLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_failed;

  // Reference model state
  int m_x, m_y, m_dx, m_dy, m_col, m_man, m_idle, m_sprev, m_hit;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs != exp) begin
      checks_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 200; m_y = 200; m_dx = 1; m_dy = 0;
    m_col = 0; m_man = 0; m_idle = 0; m_sprev = 0; m_hit = 0;
  endtask

  // Frame rules, written directly from the behavioural description.
  task automatic model_frame(input bit u, input bit d, input bit l, input bit r,
                             input bit st, input int s);
    bit toggle;
    toggle = st && (m_sprev == 0);
    m_hit = 0;
    if (m_man == 0) begin
      if (l) m_dx = 0; else if (r) m_dx = 1;
      if (u) m_dy = 0; else if (d) m_dy = 1;
      if (m_dx == 1) begin
        if (m_x + s >= MAXX) begin m_x = MAXX; m_dx = 0; m_hit = 1; end
        else m_x = m_x + s;
      end else begin
        if (m_x <= s) begin m_x = 0; m_dx = 1; m_hit = 1; end
        else m_x = m_x - s;
      end
      if (m_dy == 1) begin
        if (m_y + s >= MAXY) begin m_y = MAXY; m_dy = 0; m_hit = 1; end
        else m_y = m_y + s;
      end else begin
        if (m_y <= s) begin m_y = 0; m_dy = 1; m_hit = 1; end
        else m_y = m_y - s;
      end
      if (m_hit) m_col = (m_col + 1) % 8;
      m_man  = toggle ? 1 : 0;
      m_idle = 0;
    end else begin
      if (l && !r) m_x = (m_x - s < 0) ? 0 : m_x - s;
      else if (r && !l) m_x = (m_x + s > MAXX) ? MAXX : m_x + s;
      if (u && !d) m_y = (m_y - s < 0) ? 0 : m_y - s;
      else if (d && !u) m_y = (m_y + s > MAXY) ? MAXY : m_y + s;
      if (u || d || l || r) m_idle = 0; else m_idle = m_idle + 1;
      if (toggle) begin m_man = 0; m_idle = 0; end
      else if (m_idle >= IDLE) begin m_man = 0; m_idle = 0; end
    end
    m_sprev = st;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_left"},   int'(bus.logo_left),   m_x);
    check_eq({tag, "_top"},    int'(bus.logo_top),    m_y);
    check_eq({tag, "_color"},  int'(bus.color_index), m_col);
    check_eq({tag, "_manual"}, int'(bus.manual_mode), m_man);
  endtask

  // One full frame: sample, three busy cycles, commit, then pulse-width check.
  // Inputs are scrambled after the sampling edge to prove they were snapshot.
  task automatic do_frame(input bit u, input bit d, input bit l, input bit r,
                          input bit st, input int s, input bit dbl);
    int old_x, old_y;
    old_x = m_x;
    old_y = m_y;
    @(negedge clk);
    bus.pad_up = u; bus.pad_down = d; bus.pad_left = l; bus.pad_right = r;
    bus.pad_start = st; bus.speed = 2'(s); bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = dbl;
    bus.pad_up = 1'($urandom); bus.pad_down = 1'($urandom);
    bus.pad_left = 1'($urandom); bus.pad_right = 1'($urandom);
    bus.pad_start = 1'($urandom); bus.speed = 2'($urandom);
    check_eq("busy_c1", int'(bus.busy), 1);
    check_eq("hold_left", int'(bus.logo_left), old_x);
    @(negedge clk);
    bus.frame_start = 1'b0;
    check_eq("busy_c2", int'(bus.busy), 1);
    check_eq("hold_top", int'(bus.logo_top), old_y);
    @(negedge clk);
    check_eq("busy_c3", int'(bus.busy), 1);
    check_eq("hit_early", int'(bus.hit_pulse), 0);
    model_frame(u, d, l, r, st, s);
    @(negedge clk);
    check_eq("busy_done", int'(bus.busy), 0);
    check_eq("hit_pulse", int'(bus.hit_pulse), m_hit);
    check_state("commit");
    @(negedge clk);
    check_eq("hit_width", int'(bus.hit_pulse), 0);
    check_eq("busy_idle", int'(bus.busy), 0);
  endtask

  initial begin
    checks_total  = 0;
    checks_failed = 0;
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.speed = 2'd0;
    bus.pad_up = 1'b0; bus.pad_down = 1'b0; bus.pad_left = 1'b0;
    bus.pad_right = 1'b0; bus.pad_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_state("reset");
    check_eq("reset_busy", int'(bus.busy), 0);
    check_eq("reset_hit", int'(bus.hit_pulse), 0);

    // Start held across three frames: a single toggle into manual.
    repeat (3) do_frame(0, 0, 0, 0, 1, 0, 0);
    // Saturate against the left wall, then opposing buttons cancel.
    repeat (68) do_frame(0, 0, 1, 0, 1, 3, 0);
    do_frame(0, 0, 1, 1, 1, 3, 0);
    // Idle timeout back to auto.
    repeat (IDLE) do_frame(0, 0, 0, 0, 0, 0, 0);
    // Re-enter manual; a direction press mid-count restarts the timeout.
    do_frame(0, 0, 0, 0, 1, 0, 0);
    repeat (2) do_frame(0, 0, 0, 0, 0, 0, 0);
    do_frame(1, 0, 0, 0, 0, 0, 0);
    repeat (IDLE) do_frame(0, 0, 0, 0, 0, 0, 0);

    // Park at left=1, top=351 in manual, return to auto, hit the corner.
    do_frame(0, 0, 0, 0, 1, 0, 0);
    repeat (4) do_frame(0, 0, 1, 0, 0, 3, 0);
    do_frame(0, 0, 0, 1, 0, 1, 0);
    repeat (120) do_frame(0, 1, 0, 0, 0, 3, 0);
    do_frame(1, 0, 0, 0, 0, 1, 0);
    do_frame(0, 0, 0, 0, 1, 0, 0);
    do_frame(0, 1, 1, 0, 1, 3, 0);

    // Park at left=511 facing right, then step onto the right wall.
    do_frame(0, 0, 0, 0, 0, 0, 0);
    do_frame(0, 0, 0, 0, 1, 0, 0);
    repeat (170) do_frame(0, 0, 0, 1, 0, 3, 0);
    do_frame(0, 0, 0, 1, 0, 1, 0);
    do_frame(0, 0, 0, 0, 1, 0, 0);
    do_frame(0, 0, 0, 0, 1, 1, 0);

    // A second frame_start while busy is dropped.
    do_frame(0, 0, 0, 0, 0, 2, 1);
    repeat (3) @(negedge clk);
    check_state("no_requeue");

    // Reset during CALC_Y aborts to reset values at once.
    @(negedge clk);
    bus.speed = 2'd3; bus.pad_left = 1'b1; bus.pad_start = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midreset");
    check_eq("midreset_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(0, 0, 0, 0, 0, 3, 0);

    // Random frames.
    for (int i = 0; i < 400; i++) begin
      do_frame(1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0),
               1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0),
               1'($urandom_range(7, 0) == 0), int'($urandom_range(3, 0)),
               1'($urandom_range(7, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", checks_failed, checks_total);
    $finish;
  end

endmodule
